// File: rtl/xor_dp_scheduler.sv
// Round-robin scheduler sharing one skewed 3-input XOR datapath among NREQ
// requesters. s1 is driven one cycle ahead of s2/r so the datapath's internal
// skew lines up. Results come back four cycles after the grant, tagged with
// the requester index.
module xor_dp_scheduler #(
    parameter int NREQ        = 4,
    parameter int ID_W        = 2,
    parameter int INIT_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    input  logic [NREQ-1:0] req_a_i,
    input  logic [NREQ-1:0] req_b_i,
    input  logic [NREQ-1:0] req_c_i,
    output logic            dp_rst_o,
    output logic            dp_s1_o,
    output logic            dp_s2_o,
    output logic            dp_r_o,
    input  logic            dp_o_i,
    output logic            rsp_valid_o,
    output logic            rsp_data_o,
    output logic [ID_W-1:0] rsp_id_o,
    output logic            idle_o
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam int         CNT_W    = $clog2(INIT_CYCLES + 1);

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_init_cnt;
    logic [ID_W-1:0] r_ptr;

    // Stage-valid shift register: bit 0 = stage 1 (s1 driven), bit 3 = response.
    logic [3:0]      r_vld;
    logic            r_b1, r_c1;
    logic [ID_W-1:0] r_id1, r_id2, r_id3;

    logic            w_found;
    logic [ID_W-1:0] w_gidx;
    logic [ID_W:0]   w_cand;
    logic            w_fire;

    // Round-robin search: first valid requester at or after the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NREQ))
                w_cand = w_cand - (ID_W+1)'(NREQ);
            if (!w_found && req_valid_i[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[ID_W-1:0];
            end
        end
    end

    // Grants only while running and still enabled; dropping enable blocks that same cycle.
    assign w_fire      = (r_state == ST_RUN) && enable_i && w_found;
    assign req_ready_o = w_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gidx) : '0;
    assign dp_rst_o    = (r_state == ST_INIT);
    assign idle_o      = (r_state == ST_IDLE);
    assign rsp_valid_o = r_vld[3];

    // Control FSM, init counter and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_fire)
                r_ptr <= (w_gidx == ID_W'(NREQ-1)) ? '0 : w_gidx + 1'b1;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == CNT_W'(INIT_CYCLES-1))
                        r_state <= ST_IDLE;
                end
                ST_IDLE:  if (enable_i) r_state <= ST_RUN;
                ST_RUN:   if (!enable_i) r_state <= ST_DRAIN;
                default:  if (r_vld == '0) r_state <= ST_IDLE;
            endcase
        end
    end

    // Issue pipeline; bubbles carry zero operands and a zero valid bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld   <= '0;
            dp_s1_o <= 1'b0;
            r_b1    <= 1'b0;
            r_c1    <= 1'b0;
            r_id1   <= '0;
            dp_s2_o <= 1'b0;
            dp_r_o  <= 1'b0;
            r_id2   <= '0;
            r_id3   <= '0;
        end else begin
            r_vld   <= {r_vld[2:0], w_fire};
            dp_s1_o <= w_fire & req_a_i[w_gidx];
            r_b1    <= w_fire & req_b_i[w_gidx];
            r_c1    <= w_fire & req_c_i[w_gidx];
            r_id1   <= w_gidx;
            dp_s2_o <= r_b1;
            dp_r_o  <= r_c1;
            r_id2   <= r_id1;
            r_id3   <= r_id2;
        end
    end

    // Capture the datapath result when the third stage holds a real op; hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_data_o <= 1'b0;
            rsp_id_o   <= '0;
        end else if (r_vld[2]) begin
            rsp_data_o <= dp_o_i;
            rsp_id_o   <= r_id3;
        end
    end

endmodule

// File: tb/tb_xor_dp_scheduler.sv
module tb_xor_dp_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] req_valid = '0, req_a = '0, req_b = '0, req_c = '0;
    logic [3:0] req_ready;
    logic       dp_rst, dp_s1, dp_s2, dp_r, dp_o;
    logic       rsp_valid, rsp_data, idle;
    logic [1:0] rsp_id;

    xor_dp_scheduler #(.NREQ(4), .ID_W(2), .INIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
        .dp_rst_o(dp_rst), .dp_s1_o(dp_s1), .dp_s2_o(dp_s2), .dp_r_o(dp_r),
        .dp_o_i(dp_o),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
        .idle_o(idle)
    );

    always #5 clk = ~clk;

    // External skewed datapath: s1 two registers deep, s2/r one deep.
    logic s1q1 = 1'b0, s1q2 = 1'b0, s2q = 1'b0, rq = 1'b0;
    always @(posedge clk) begin
        if (dp_rst) begin
            s1q1 <= 1'b0; s1q2 <= 1'b0; s2q <= 1'b0; rq <= 1'b0;
        end else begin
            s1q1 <= dp_s1; s1q2 <= s1q1; s2q <= dp_s2; rq <= dp_r;
        end
    end
    assign dp_o = s1q2 ^ s2q ^ rq;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0, n_rsp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    typedef struct { logic [1:0] id; logic d; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t e;

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One cycle of stimulus; gnt < 0 means no grant expected.
    task automatic issue(input logic en, input logic [3:0] vld, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c,
                         input int gnt, input logic d, input string nm);
        logic [3:0] exp_rdy;
        @(posedge clk); #1;
        enable = en; req_valid = vld; req_a = a; req_b = b; req_c = c;
        @(negedge clk);
        exp_rdy = (gnt < 0) ? 4'b0000 : 4'(1 << gnt);
        chk(nm, 32'(req_ready), 32'(exp_rdy));
        if (gnt >= 0) exp_q.push_back('{id: 2'(gnt), d: d, cyc: cyc + 4});
    endtask

    // T3 stream: a,b,c per op and expected xor.
    logic [2:0] t3_abc [4] = '{3'b110, 3'b111, 3'b001, 3'b000};
    logic       t3_d   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    // T4: operands a=0101 b=0011 c=0000 give per-requester data 0,1,1,0.
    int         t4_g   [11] = '{3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    logic [3:0] t4_v   [11] = '{4'b1000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    logic       t4_d   [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int snap;

    initial begin
        // T1: reset values, then dp_rst_o for exactly two cycles
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_rst_outs", 32'({dp_s1, dp_s2, dp_r, rsp_valid, rsp_data, rsp_id, idle, req_ready}), 32'd0);
        chk("t1_rst_dprst", 32'(dp_rst), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("t1_dprst_c0", 32'({dp_rst, idle}), 32'b10);
        @(negedge clk); chk("t1_dprst_c1", 32'({dp_rst, idle}), 32'b10);
        @(negedge clk); chk("t1_idle", 32'({dp_rst, idle, req_ready}), 32'b010000);

        // T2: single op from requester 1
        issue(1, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t2_idle_rdy");
        issue(1, 4'b0010, 4'b0010, 4'h0, 4'h0, 1, 1, "t2_grant");
        issue(1, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t2_bubble0");
        chk("t2_s1", 32'(dp_s1), 32'd1);
        issue(1, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t2_bubble1");
        chk("t2_s1_bubble", 32'(dp_s1), 32'd0);

        // T3: back-to-back stream from requester 0 (pointer at 2, wraps to 0)
        for (int i = 0; i < 4; i++)
            issue(1, 4'b0001, {3'b0, t3_abc[i][2]}, {3'b0, t3_abc[i][1]}, {3'b0, t3_abc[i][0]},
                  0, t3_d[i], "t3_grant");

        // T4: round robin over all, then with requester 2 dropped
        for (int i = 0; i < 11; i++)
            issue(1, t4_v[i], 4'b0101, 4'b0011, 4'b0000, t4_g[i], t4_d[i], "t4_grant");

        // T5: three ops in flight, then drain (enable re-asserted in drain is ignored)
        for (int i = 0; i < 3; i++)
            issue(1, 4'b0001, 4'b0001, 4'h0, 4'h0, 0, 1, "t5_grant");
        issue(0, 4'b0001, 4'h0, 4'h0, 4'h0, -1, 0, "t5_dis");
        issue(1, 4'b0001, 4'h0, 4'h0, 4'h0, -1, 0, "t5_drain_en0");
        issue(1, 4'b0001, 4'h0, 4'h0, 4'h0, -1, 0, "t5_drain_en1");
        issue(0, 4'b0001, 4'h0, 4'h0, 4'h0, -1, 0, "t5_drain_last");
        chk("t5_not_idle_last_rsp", 32'({rsp_valid, idle}), 32'b10);
        issue(0, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t5_drain_e");
        issue(0, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t5_drain_f");
        chk("t5_idle", 32'(idle), 32'd1);

        // T6: reset two cycles after a grant discards the op
        issue(1, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t6_idle_rdy");
        issue(1, 4'b0100, 4'b0100, 4'h0, 4'h0, 2, 1, "t6_grant");
        issue(1, 4'b0000, 4'h0, 4'h0, 4'h0, -1, 0, "t6_bubble");
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t6_rst_outs", 32'({dp_s1, dp_s2, dp_r, rsp_valid, rsp_data, rsp_id, idle, req_ready}), 32'd0);
        chk("t6_rst_dprst", 32'(dp_rst), 32'd1);
        exp_q.delete();
        snap = n_rsp;
        enable = 1'b0; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("t6_dprst_repulse", 32'(dp_rst), 32'd1);
        repeat (8) @(negedge clk);
        chk("t6_no_rsp", 32'(n_rsp), 32'(snap));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
